lsu_ctrl: RTL and testbench

Load/store sequencer between the CPU's MEM stage and a handshaked data memory. It checks alignment, generates byte enables and lane-replicated store data, and holds the pipeline stall while an access is outstanding. It returns the raw read word together with the extension opcode and byte offset that drive the downstream load-extension unit. Each valid MEM-stage access is issued to memory exactly once.

---
 rtl/lsu_pkg.sv | 20 ++
 rtl/lsu_lane.sv | 48 ++++
 rtl/lsu_ctrl.sv | 151 +++++++++++++++
 tb/tb_lsu_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and encodings for the load/store unit and the downstream load-extension unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } lsu_state_e;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  localparam logic [2:0] EXT_WORD = 3'b000;
  localparam logic [2:0] EXT_LBU  = 3'b001;
  localparam logic [2:0] EXT_LB   = 3'b010;
  localparam logic [2:0] EXT_LHU  = 3'b011;
  localparam logic [2:0] EXT_LH   = 3'b100;

endpackage

// File: rtl/lsu_lane.sv
// Combinational lane logic: alignment check, byte enables, store-data replication, ext_op encoding.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic        we_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  output logic        aligned_o,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [2:0]  ext_op_o
);

  logic [3:0] byte_sel;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte_sel
      assign byte_sel[gi] = (addr_lo_i == 2'(gi));
    end
  endgenerate

  always_comb begin
    aligned_o = 1'b1;
    be_o      = 4'b1111;
    wdata_o   = wdata_i;
    ext_op_o  = EXT_WORD;
    case (size_i)
      SZ_HALF: begin
        aligned_o = ~addr_lo_i[0];
        be_o      = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o   = {2{wdata_i[15:0]}};
        ext_op_o  = unsigned_i ? EXT_LHU : EXT_LH;
      end
      SZ_BYTE: begin
        be_o      = byte_sel;
        wdata_o   = {4{wdata_i[7:0]}};
        ext_op_o  = unsigned_i ? EXT_LBU : EXT_LB;
      end
      // Word and the reserved encoding behave identically.
      default: aligned_o = (addr_lo_i == 2'b00);
    endcase
    if (we_i) ext_op_o = EXT_WORD;
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer between MEM stage and a handshaked data memory.
// Define LSU_TIMEOUT_EN to add a BUSY watchdog that aborts the access and pulses bus_err.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        rd_valid,
  output logic [31:0] rd_raw,
  output logic [2:0]  ext_op,
  output logic [1:0]  ext_lo,
  output logic        adel,
  output logic        ades,
  output logic        bus_err
);

  lsu_state_e  state_q, state_d;
  logic [29:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [31:0] rd_raw_q;
  logic        we_q;
  logic [2:0]  ext_op_q;
  logic [1:0]  ext_lo_q;
  logic        adel_q, ades_q;

  logic        aligned;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [2:0]  lane_ext;
  logic        in_idle, in_busy, in_done;
  logic        accept, misalign, timeout_hit;

  lsu_lane u_lane (
    .size_i    (req_size),
    .unsigned_i(req_unsigned),
    .we_i      (req_we),
    .addr_lo_i (req_addr[1:0]),
    .wdata_i   (req_wdata),
    .aligned_o (aligned),
    .be_o      (lane_be),
    .wdata_o   (lane_wdata),
    .ext_op_o  (lane_ext)
  );

  assign in_idle  = (state_q == ST_IDLE);
  assign in_busy  = (state_q == ST_BUSY);
  assign in_done  = (state_q == ST_DONE);
  assign accept   = in_idle & req_valid & aligned;
  assign misalign = in_idle & req_valid & ~aligned;

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYC > 255) ? $clog2(TIMEOUT_CYC + 1) : 8;

  logic [CNT_W-1:0] cnt_q;
  logic             bus_err_q;

  // Fires on the last allowed BUSY cycle, so BUSY lasts exactly TIMEOUT_CYC cycles.
  assign timeout_hit = in_busy & ~mem_ack & (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      bus_err_q <= timeout_hit;
      if (accept)       cnt_q <= '0;
      else if (in_busy) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus_err = bus_err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC != 0);
  assign timeout_hit    = 1'b0;
  assign bus_err        = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_BUSY;
      ST_BUSY: if (mem_ack || timeout_hit) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      ext_op_q <= EXT_WORD;
      ext_lo_q <= '0;
      rd_raw_q <= '0;
      adel_q   <= 1'b0;
      ades_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      adel_q  <= misalign & ~req_we;
      ades_q  <= misalign & req_we;
      if (accept) begin
        addr_q   <= req_addr[31:2];
        be_q     <= lane_be;
        wdata_q  <= lane_wdata;
        we_q     <= req_we;
        ext_op_q <= lane_ext;
        ext_lo_q <= req_addr[1:0];
      end
      // A timed-out load returns zero so stale data never reaches the register file.
      if (in_busy && !we_q) begin
        if (mem_ack)          rd_raw_q <= mem_rdata;
        else if (timeout_hit) rd_raw_q <= '0;
      end
    end
  end

  assign stall     = accept | in_busy;
  assign mem_req   = in_busy;
  assign mem_we    = in_busy & we_q;
  assign mem_be    = be_q;
  assign mem_addr  = {addr_q, 2'b00};
  assign mem_wdata = wdata_q;
  assign rd_valid  = in_done & ~we_q;
  assign rd_raw    = rd_raw_q;
  assign ext_op    = ext_op_q;
  assign ext_lo    = ext_lo_q;
  assign adel      = adel_q;
  assign ades      = ades_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed self-checking bench for lsu_ctrl; memory handshake is driven directly from the stimulus.
module tb_lsu_ctrl;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        rd_valid;
  logic [31:0] rd_raw;
  logic [2:0]  ext_op;
  logic [1:0]  ext_lo;
  logic        adel;
  logic        ades;
  logic        bus_err;

  int n_cmp = 0;
  int n_mis = 0;

  lsu_ctrl #(.TIMEOUT_CYC(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_we      (req_we),
    .req_size    (req_size),
    .req_unsigned(req_unsigned),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .stall       (stall),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_be      (mem_be),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .rd_valid    (rd_valid),
    .rd_raw      (rd_raw),
    .ext_op      (ext_op),
    .ext_lo      (ext_lo),
    .adel        (adel),
    .ades        (ades),
    .bus_err     (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns later.
  task automatic access(input string name, input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                        input int k, input logic [31:0] rdata, input logic [3:0] exp_be,
                        input logic [31:0] exp_wdata, input logic [2:0] exp_ext,
                        input logic [1:0] exp_lo);
    int stall_cnt;
    stall_cnt = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    #1;
    chk({name, ".c0_mem_req"}, 32'(mem_req), 32'd0);
    if (stall) stall_cnt++;
    for (int c = 1; c <= k; c++) begin
      @(negedge clk);
      if (c == k) begin mem_ack = 1'b1; mem_rdata = rdata; end
      #1;
      chk({name, ".mem_req"}, 32'(mem_req), 32'd1);
      if (stall) stall_cnt++;
      if (c == 1) begin
        chk({name, ".mem_be"}, 32'(mem_be), 32'(exp_be));
        chk({name, ".mem_addr"}, mem_addr, {addr[31:2], 2'b00});
        chk({name, ".mem_we"}, 32'(mem_we), 32'(we));
        chk({name, ".ext_op"}, 32'(ext_op), 32'(exp_ext));
        chk({name, ".ext_lo"}, 32'(ext_lo), 32'(exp_lo));
        if (we) chk({name, ".mem_wdata"}, mem_wdata, exp_wdata);
      end
    end
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = 32'h0;
    #1;
    chk({name, ".done_rd_valid"}, 32'(rd_valid), 32'(!we));
    chk({name, ".done_stall"}, 32'(stall), 32'd0);
    chk({name, ".done_mem_req"}, 32'(mem_req), 32'd0);
    if (!we) chk({name, ".rd_raw"}, rd_raw, rdata);
    chk({name, ".stall_cycles"}, 32'(stall_cnt), 32'(k + 1));
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    chk({name, ".idle_rd_valid"}, 32'(rd_valid), 32'd0);
    chk({name, ".idle_stall"}, 32'(stall), 32'd0);
    $display("txn %s we=%0d size=%0d addr=0x%08h ack@%0d be=%b ext=%0d lo=%0d raw=0x%08h",
             name, we, size, addr, k, exp_be, exp_ext, exp_lo, rd_raw);
  endtask

  task automatic misaligned(input string name, input logic we, input logic [1:0] size,
                            input logic [31:0] addr);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = 1'b0;
    req_addr = addr; req_wdata = 32'h0;
    #1;
    chk({name, ".c0_stall"}, 32'(stall), 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    chk({name, ".adel"}, 32'(adel), 32'(!we));
    chk({name, ".ades"}, 32'(ades), 32'(we));
    chk({name, ".c1_mem_req"}, 32'(mem_req), 32'd0);
    chk({name, ".c1_stall"}, 32'(stall), 32'd0);
    @(negedge clk);
    #1;
    chk({name, ".pulse_end"}, 32'(adel | ades), 32'd0);
    chk({name, ".c2_mem_req"}, 32'(mem_req), 32'd0);
    $display("txn %s misaligned we=%0d size=%0d addr=0x%08h", name, we, size, addr);
  endtask

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    #1;
    chk("rst.stall", 32'(stall), 32'd0);
    chk("rst.mem_req", 32'(mem_req), 32'd0);
    chk("rst.rd_raw", rd_raw, 32'h0);
    chk("rst.ext_op", 32'(ext_op), 32'd0);
    chk("rst.rd_valid", 32'(rd_valid), 32'd0);
    chk("rst.bus_err", 32'(bus_err), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    $display("txn reset released");

    access("lw_100", 1'b0, 2'b00, 1'b0, 32'h0000_0100, 32'h0, 3, 32'hDEAD_BEEF,
           4'b1111, 32'h0, 3'b000, 2'b00);
    access("sb_203", 1'b1, 2'b10, 1'b0, 32'h0000_0203, 32'h0000_00A5, 1, 32'h0,
           4'b1000, 32'hA5A5_A5A5, 3'b000, 2'b11);
    access("lh_102", 1'b0, 2'b01, 1'b0, 32'h0000_0102, 32'h0, 2, 32'h8001_7F00,
           4'b1100, 32'h0, 3'b100, 2'b10);
    access("lbu_101", 1'b0, 2'b10, 1'b1, 32'h0000_0101, 32'h0, 2, 32'h0000_C300,
           4'b0010, 32'h0, 3'b001, 2'b01);
    access("lb_402", 1'b0, 2'b10, 1'b0, 32'h0000_0402, 32'h0, 1, 32'h0055_0000,
           4'b0100, 32'h0, 3'b010, 2'b10);
    access("sh_102", 1'b1, 2'b01, 1'b0, 32'h0000_0102, 32'h1234_ABCD, 2, 32'h0,
           4'b1100, 32'hABCD_ABCD, 3'b000, 2'b10);
    access("lhu_500", 1'b0, 2'b01, 1'b1, 32'h0000_0500, 32'h0, 1, 32'h0000_FFFE,
           4'b0011, 32'h0, 3'b011, 2'b00);
    access("lw_rsv_600", 1'b0, 2'b11, 1'b0, 32'h0000_0600, 32'h0, 1, 32'h0BAD_F00D,
           4'b1111, 32'h0, 3'b000, 2'b00);

    misaligned("lh_101", 1'b0, 2'b01, 32'h0000_0101);
    misaligned("sw_102", 1'b1, 2'b00, 32'h0000_0102);

    // An ack arriving while idle must not disturb the latched read word.
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = 32'h0;
    #1;
    chk("idle_ack.rd_raw", rd_raw, 32'h0BAD_F00D);
    chk("idle_ack.rd_valid", 32'(rd_valid), 32'd0);
    chk("idle_ack.stall", 32'(stall), 32'd0);
    $display("txn stray ack in IDLE ignored");

    // Reset pulled low while a store waits for its ack.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_addr = 32'h0000_0300;
    req_wdata = 32'h1111_2222;
    @(negedge clk);
    #1;
    chk("rst_busy.mem_req_before", 32'(mem_req), 32'd1);
    @(negedge clk);
    #2;
    reset = 1'b0; req_valid = 1'b0;
    #1;
    chk("rst_busy.mem_req_now", 32'(mem_req), 32'd0);
    chk("rst_busy.stall", 32'(stall), 32'd0);
    chk("rst_busy.mem_be", 32'(mem_be), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    $display("txn reset during BUSY store");
    access("lw_104", 1'b0, 2'b00, 1'b0, 32'h0000_0104, 32'h0, 2, 32'h1234_5678,
           4'b1111, 32'h0, 3'b000, 2'b00);

`ifdef LSU_TIMEOUT_EN
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b00; req_addr = 32'h0000_0010;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      #1;
      chk("tmo.mem_req", 32'(mem_req), 32'd1);
      chk("tmo.bus_err_early", 32'(bus_err), 32'd0);
    end
    @(negedge clk);
    #1;
    chk("tmo.bus_err", 32'(bus_err), 32'd1);
    chk("tmo.rd_valid", 32'(rd_valid), 32'd1);
    chk("tmo.rd_raw", rd_raw, 32'h0);
    chk("tmo.mem_req_drop", 32'(mem_req), 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    chk("tmo.idle_bus_err", 32'(bus_err), 32'd0);
    chk("tmo.idle_stall", 32'(stall), 32'd0);
    chk("tmo.idle_rd_valid", 32'(rd_valid), 32'd0);
    $display("txn load timeout at 0x00000010");
    access("lw_after_tmo", 1'b0, 2'b00, 1'b0, 32'h0000_0020, 32'h0, 1, 32'hCAFE_0001,
           4'b1111, 32'h0, 3'b000, 2'b00);
`else
    chk("no_tmo.bus_err", 32'(bus_err), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
